// File: rtl/cmp_sort4_ctrl.sv
// cmp_sort4_ctrl: four-element sorter sharing one 8-bit comparator across a six-step bubble network
module cmp_8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       lt,
  output logic       eq,
  output logic       gt
);
  assign lt = a < b;
  assign eq = a == b;
  assign gt = a > b;
endmodule

module cmp_sort4_ctrl #(
  parameter int DATA_W = 8,
  parameter int N_ELEM = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     desc,
  input  logic [DATA_W*N_ELEM-1:0] din,
  output logic [DATA_W*N_ELEM-1:0] dout,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               swaps
);
  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] step_q, step_d, cnt_q, cnt_d, swaps_q, swaps_d;
  logic [N_ELEM-1:0][DATA_W-1:0] elem_q, elem_d;
  logic [DATA_W*N_ELEM-1:0] dout_q, dout_d;
  logic desc_q, desc_d, busy_q, busy_d, done_q, done_d;
  logic [1:0] idx;
  logic lt, eq, gt, swap;
  // step -> lower index of the pair: (0,1),(1,2),(2,3),(0,1),(1,2),(0,1)
  assign idx = (step_q == 3'd1 || step_q == 3'd4) ? 2'd1 : (step_q == 3'd2) ? 2'd2 : 2'd0;
  cmp_8b u_cmp (
    .a  (elem_q[idx]),
    .b  (elem_q[idx + 2'd1]),
    .lt (lt),
    .eq (eq),
    .gt (gt)
  );
  // ties never exchange, keeping the sort stable
  assign swap = !eq && (desc_q ? lt : gt);
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    elem_d  = elem_q;
    desc_d  = desc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    swaps_d = swaps_q;
    done_d  = 1'b0;
    if (state_q == IDLE && start) begin
      state_d = SORT;
      elem_d  = din;
      desc_d  = desc;
      cnt_d   = 3'd0;
      step_d  = 3'd0;
    end else if (state_q == SORT) begin
      if (swap) begin
        elem_d[idx]        = elem_q[idx + 2'd1];
        elem_d[idx + 2'd1] = elem_q[idx];
        cnt_d              = cnt_q + 3'd1;
      end
      step_d = step_q + 3'd1;
      if (step_q == 3'd5) begin
        state_d = DONE;
        step_d  = 3'd0;
        done_d  = 1'b1;
        dout_d  = elem_d;
        swaps_d = cnt_d;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d == SORT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      elem_q  <= '0;
      desc_q  <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= '0;
      swaps_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      elem_q  <= elem_d;
      desc_q  <= desc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      swaps_q <= swaps_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign dout  = dout_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign swaps = swaps_q;
endmodule

// File: tb/tb_cmp_sort4_ctrl.sv
// tb_cmp_sort4_ctrl: directed vectors with hand-computed sorted results, latencies and swap counts
module tb_cmp_sort4_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, desc = 1'b0;
  logic [31:0] din = '0, dout;
  logic busy, done;
  logic [2:0] swaps;
  int total = 0, bad = 0;

  cmp_sort4_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .desc  (desc),
    .din   (din),
    .dout  (dout),
    .busy  (busy),
    .done  (done),
    .swaps (swaps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // drive at negedge, sample at negedge; done expected on the 7th negedge after the sampling edge
  task automatic run_sort(input string tag, input logic [31:0] d, input logic m,
                          input logic [31:0] exp_dout, input logic [2:0] exp_swaps);
    int lat;
    lat = 0;
    @(negedge clk);
    din = d; desc = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    for (int k = 2; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (done) lat = k;
    end
    chk({tag, "_lat"}, lat, 32'd7);
    chk({tag, "_dout"}, dout, exp_dout);
    chk({tag, "_swaps"}, {29'b0, swaps}, {29'b0, exp_swaps});
    chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int n_done, n_busy, t1, t2;
    #1;
    chk("rst_dout", dout, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_swaps", {29'b0, swaps}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sort("asc1", 32'h03FF0310, 1'b0, 32'hFF100303, 3'd3);
    run_sort("desc1", 32'h03FF0310, 1'b1, 32'h030310FF, 3'd2);
    run_sort("rev", 32'h01020304, 1'b0, 32'h04030201, 3'd6);
    run_sort("sorted", 32'h04030201, 1'b0, 32'h04030201, 3'd0);
    run_sort("desc_rev", 32'h04030201, 1'b1, 32'h01020304, 3'd6);
    repeat (3) @(negedge clk);
    chk("hold_dout", dout, 32'h01020304);
    chk("hold_swaps", {29'b0, swaps}, 32'd6);

    // start held high: two complete sorts in the first 16 cycles
    n_done = 0; n_busy = 0; t1 = 0; t2 = 0;
    din = 32'h10203040; desc = 1'b0; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 16) begin
        if (busy) n_busy++;
        if (done) begin
          n_done++;
          if (t1 == 0) t1 = k; else t2 = k;
        end
      end
    end
    start = 1'b0;
    chk("hold_ndone", n_done, 32'd2);
    chk("hold_gap", t2 - t1, 32'd8);
    chk("hold_first", t1, 32'd7);
    chk("hold_nbusy", n_busy, 32'd12);
    repeat (10) @(negedge clk);
    chk("hold_result", dout, 32'h40302010);

    // reset during step 3 aborts with no done
    n_done = 0;
    din = 32'h01020304; desc = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_dout", dout, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_swaps", {29'b0, swaps}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_nodone", n_done, 32'd0);
    run_sort("after_rst", 32'h03FF0310, 1'b0, 32'hFF100303, 3'd3);

    // inputs changing mid-sort must not affect the loaded values
    @(negedge clk);
    din = 32'h03FF0310; desc = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; din = 32'h01020304; desc = 1'b0;
    n_done = 0;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      if (k == 3) begin din = 32'hAABBCCDD; desc = 1'b1; end
      if (done) n_done++;
    end
    chk("chg_done", n_done, 32'd1);
    chk("chg_dout", dout, 32'h030310FF);
    chk("chg_swaps", {29'b0, swaps}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
